// File: rtl/tanh_pkg.sv
// Shared constants and FSM state type for the tanh table reader
// and the downstream linear interpolator.
package tanh_pkg;

    localparam int DATA_W      = 8;
    localparam int FRAC_W      = 4;
    localparam int ADDR_W      = 5;
    localparam int TABLE_DEPTH = (1 << (DATA_W - FRAC_W)) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_NEXT,
        ST_CAP_BASE,
        ST_CAP_NEXT,
        ST_OUT
    } state_e;

endpackage

// File: rtl/tanh_lut_fetcher.sv
// Splits a signed sample into table index and fraction, reads two
// adjacent tanh breakpoints from an external ROM, presents operands.
module tanh_lut_fetcher #(
    parameter int DATA_W = tanh_pkg::DATA_W,
    parameter int FRAC_W = tanh_pkg::FRAC_W,
    parameter int ADDR_W = tanh_pkg::ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x,
    output logic                     rom_en,
    output logic        [ADDR_W-1:0] rom_addr,
    input  logic signed [DATA_W-1:0] rom_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] base,
    output logic signed [DATA_W-1:0] next_data,
    output logic signed [DATA_W-1:0] change,
    output logic signed [DATA_W-1:0] remaining
);

    import tanh_pkg::*;

    state_e                     state_q;
    logic                       rom_en_q;
    logic        [ADDR_W-1:0]   rom_addr_q;
    logic signed [DATA_W-1:0]   base_q;
    logic signed [DATA_W-1:0]   next_q;
    logic signed [DATA_W-1:0]   change_q;
    logic signed [DATA_W-1:0]   rem_q;
    logic                       out_valid_q;

    logic        [ADDR_W-1:0]   addr_d;
    logic signed [DATA_W-1:0]   rem_d;

    // Signed index + half-table offset is just the index with its
    // sign bit inverted; the fraction is zero-extended.
    assign addr_d = ADDR_W'({~x[DATA_W-1], x[DATA_W-2:FRAC_W]});
    assign rem_d  = DATA_W'(x[FRAC_W-1:0]);

    // Fetch sequencer: two back-to-back reads, capture, hold until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            base_q      <= '0;
            next_q      <= '0;
            change_q    <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        rom_addr_q <= addr_d;
                        rem_q      <= rem_d;
                        rom_en_q   <= 1'b1;
                        state_q    <= ST_REQ_NEXT;
                    end
                end
                ST_REQ_NEXT: begin
                    rom_addr_q <= rom_addr_q + ADDR_W'(1);
                    state_q    <= ST_CAP_BASE;
                end
                ST_CAP_BASE: begin
                    base_q   <= rom_data;
                    rom_en_q <= 1'b0;
                    state_q  <= ST_CAP_NEXT;
                end
                ST_CAP_NEXT: begin
                    next_q      <= rom_data;
                    change_q    <= rom_data - base_q;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign rom_en    = rom_en_q;
    assign rom_addr  = rom_addr_q;
    assign out_valid = out_valid_q;
    assign base      = base_q;
    assign next_data = next_q;
    assign change    = change_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_tanh_lut_fetcher.sv
// Directed bench for tanh_lut_fetcher with a linear-table ROM model
// (entry i = 8*i - 64, one-cycle read latency).
module tb_tanh_lut_fetcher;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] x;
    logic              rom_en;
    logic        [4:0] rom_addr;
    logic signed [7:0] rom_data;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] base;
    logic signed [7:0] next_data;
    logic signed [7:0] change;
    logic signed [7:0] remaining;

    int vectors;
    int errors;

    tanh_lut_fetcher dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .base      (base),
        .next_data (next_data),
        .change    (change),
        .remaining (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model
    always @(posedge clk) begin
        if (rom_en)
            rom_data <= 8'(8 * int'(rom_addr) - 64);
    end

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept one sample and follow it to the cycle out_valid rises.
    task automatic fetch(input logic [7:0] xv, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] n,
                         input logic [7:0] r);
        @(negedge clk);
        x = xv;
        in_valid = 1'b1;
        chk("in_ready_idle", 8'(in_ready), 8'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("e0_rom_en", 8'(rom_en), 8'd1);
        chk("e0_rom_addr", 8'(rom_addr), a);
        chk("e0_in_ready", 8'(in_ready), 8'd0);
        chk("e0_out_valid", 8'(out_valid), 8'd0);
        @(posedge clk); #1;
        chk("e1_rom_en", 8'(rom_en), 8'd1);
        chk("e1_rom_addr", 8'(rom_addr), 8'(a + 8'd1));
        @(posedge clk); #1;
        chk("e2_rom_en", 8'(rom_en), 8'd0);
        chk("e2_base", base, b);
        chk("e2_out_valid", 8'(out_valid), 8'd0);
        @(posedge clk); #1;
        chk("e3_out_valid", 8'(out_valid), 8'd1);
        chk("e3_base", base, b);
        chk("e3_next", next_data, n);
        chk("e3_change", change, 8'(n - b));
        chk("e3_remaining", remaining, r);
    endtask

    task automatic drain();
        @(posedge clk); #1;
        chk("hs_out_valid", 8'(out_valid), 8'd0);
        chk("hs_in_ready", 8'(in_ready), 8'd1);
    endtask

    initial begin
        int seen;
        vectors   = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        x         = '0;
        out_ready = 1'b1;

        // reset values while asserted
        #3;
        chk("rst_in_ready", 8'(in_ready), 8'd1);
        chk("rst_out_valid", 8'(out_valid), 8'd0);
        chk("rst_rom_en", 8'(rom_en), 8'd0);
        chk("rst_rom_addr", 8'(rom_addr), 8'd0);
        chk("rst_base", base, 8'd0);
        chk("rst_next", next_data, 8'd0);
        chk("rst_change", change, 8'd0);
        chk("rst_remaining", remaining, 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_in_ready", 8'(in_ready), 8'd1);
        chk("rel_out_valid", 8'(out_valid), 8'd0);
        chk("rel_rom_en", 8'(rom_en), 8'd0);
        chk("rel_base", base, 8'd0);

        // nominal sample
        fetch(8'h35, 8'd11, 8'd24, 8'd32, 8'd5);
        drain();

        // most negative and most positive samples
        fetch(8'h80, 8'd0, 8'hC0, 8'hC8, 8'd0);
        drain();
        fetch(8'h7F, 8'd15, 8'd56, 8'd64, 8'd15);
        drain();

        // back-pressure: hold five cycles, stray in_valid ignored
        out_ready = 1'b0;
        fetch(8'h35, 8'd11, 8'd24, 8'd32, 8'd5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i == 2);
            x = 8'h10;
            @(posedge clk); #1;
            chk("bp_out_valid", 8'(out_valid), 8'd1);
            chk("bp_in_ready", 8'(in_ready), 8'd0);
            chk("bp_base", base, 8'd24);
            chk("bp_next", next_data, 8'd32);
            chk("bp_change", change, 8'd8);
            chk("bp_remaining", remaining, 8'd5);
            chk("bp_rom_en", 8'(rom_en), 8'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        @(posedge clk); #1;
        chk("bp_idle_rom_en", 8'(rom_en), 8'd0);
        chk("bp_idle_out_valid", 8'(out_valid), 8'd0);
        chk("bp_idle_in_ready", 8'(in_ready), 8'd1);

        // back-to-back with out_ready held high
        fetch(8'h00, 8'd8, 8'd0, 8'd8, 8'd0);
        drain();
        fetch(8'h10, 8'd9, 8'd8, 8'd16, 8'd0);
        drain();
        fetch(8'hF0, 8'd7, 8'hF8, 8'd0, 8'd0);
        drain();

        // reset pulsed during CAP_BASE drops the sample
        @(negedge clk);
        x = 8'h35;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_rom_en_before", 8'(rom_en), 8'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rom_en", 8'(rom_en), 8'd0);
        chk("mid_out_valid", 8'(out_valid), 8'd0);
        chk("mid_rom_addr", 8'(rom_addr), 8'd0);
        chk("mid_in_ready", 8'(in_ready), 8'd1);
        chk("mid_remaining", remaining, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("mid_no_output", 8'(seen), 8'd0);
        chk("mid_rom_idle", 8'(rom_en), 8'd0);

        fetch(8'h35, 8'd11, 8'd24, 8'd32, 8'd5);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
